// File: rtl/fetch_decode_stage.sv
// MIPS instruction fetch plus IF/ID pipeline register: PC drives imem_addr, word latched with its PC one cycle later.
// stall freezes PC and IF/ID; redirect beats stall for the PC, flush beats stall for IF/ID.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic [25:0] id_target26
);

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_id_instr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // A redirect without stall drops the wrong-path word currently at imem_addr.
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && redirect_valid)) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_pc4   <= 32'h0000_0000;
            r_id_instr <= NOP_WORD;
        end else if (!stall) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc_plus4;
            r_id_instr <= imem_rdata;
        end
    end

    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc4;
    assign id_instr    = r_id_instr;
    assign id_opcode   = r_id_instr[31:26];
    assign id_rs       = r_id_instr[25:21];
    assign id_rt       = r_id_instr[20:16];
    assign id_rd       = r_id_instr[15:11];
    assign id_shamt    = r_id_instr[10:6];
    assign id_funct    = r_id_instr[5:0];
    assign id_imm16    = r_id_instr[15:0];
    assign id_target26 = r_id_instr[25:0];

endmodule
